// File: rtl/irq_request_latch.sv
// ============================================================================
// Module   : irq_request_latch
// Brief    : Latches raw interrupt lines into pending bits for the controller
//            and flags edges lost while a line was already pending.
//            Optional input synchronizer enabled by macro IRQ_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_request_latch #(
    parameter int N_IRQ       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             INT_RST_N,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_edge,
    input  logic [N_IRQ-1:0] sw_set,
    input  logic [N_IRQ-1:0] int_fin,
    input  logic [N_IRQ-1:0] lost_clr,
    output logic [N_IRQ-1:0] int_req,
    output logic [N_IRQ-1:0] irq_lost,
    output logic             irq_any
);

    logic [N_IRQ-1:0] w_s;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_set;
    logic [N_IRQ-1:0] w_lost_set;
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_lost;

`ifdef IRQ_SYNC_EN
    if (1) begin : g_sync
        logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;

        always_ff @(posedge clock or negedge INT_RST_N) begin
            if (!INT_RST_N) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];
    end
`else
    assign w_s = irq_in;
`endif

    // Set beats a same-cycle completion, so a level line still high re-pends.
    always_comb begin
        w_rise     = w_s & ~r_prev;
        w_set      = (irq_edge & w_rise) | (~irq_edge & w_s) | sw_set;
        w_lost_set = irq_edge & w_rise & r_pend & ~int_fin;
    end

    always_ff @(posedge clock or negedge INT_RST_N) begin
        if (!INT_RST_N) begin
            r_prev <= '0;
            r_pend <= '0;
            r_lost <= '0;
        end else begin
            r_prev <= w_s;
            r_pend <= w_set | (r_pend & ~int_fin);
            r_lost <= w_lost_set | (r_lost & ~lost_clr);
        end
    end

    assign int_req  = r_pend;
    assign irq_lost = r_lost;
    assign irq_any  = |r_pend;

endmodule

`default_nettype wire

// File: tb/tb_irq_request_latch.sv
// ============================================================================
// Module   : tb_irq_request_latch
// Brief    : Self-checking bench: directed vector table, hand-written corner
//            sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_request_latch;

`ifdef IRQ_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic        clock;
    logic        INT_RST_N;
    logic [31:0] irq_in, irq_edge, sw_set, int_fin, lost_clr;
    logic [31:0] int_req, irq_lost;
    logic        irq_any;

    int n_checks = 0;
    int n_pass   = 0;

    irq_request_latch #(.N_IRQ(32), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .INT_RST_N(INT_RST_N),
        .irq_in   (irq_in),
        .irq_edge (irq_edge),
        .sw_set   (sw_set),
        .int_fin  (int_fin),
        .lost_clr (lost_clr),
        .int_req  (int_req),
        .irq_lost (irq_lost),
        .irq_any  (irq_any)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: delayed line samples in a queue, per-line rules in a loop.
    bit [31:0] m_prev, m_pend, m_lost;
    bit [31:0] m_q[$];

    function automatic void model_reset();
        m_prev = '0;
        m_pend = '0;
        m_lost = '0;
        m_q.delete();
        for (int i = 0; i < SYNC; i++) m_q.push_back('0);
    endfunction

    function automatic void model_step();
        bit [31:0] s, np, nl;
        bit rise;
        if (SYNC == 0) begin
            s = irq_in;
        end else begin
            s = m_q.pop_front();
            m_q.push_back(irq_in);
        end
        for (int i = 0; i < 32; i++) begin
            rise  = s[i] && !m_prev[i];
            np[i] = (irq_edge[i] ? rise : s[i]) || sw_set[i] || (m_pend[i] && !int_fin[i]);
            nl[i] = (irq_edge[i] && rise && m_pend[i] && !int_fin[i]) || (m_lost[i] && !lost_clr[i]);
        end
        m_prev = s;
        m_pend = np;
        m_lost = nl;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".int_req"}, int_req, m_pend);
        chk({tag, ".irq_lost"}, irq_lost, m_lost);
        chk({tag, ".irq_any"}, {31'd0, irq_any}, {31'd0, |m_pend});
    endtask

    task automatic clear_inputs();
        irq_in = '0; irq_edge = '0; sw_set = '0; int_fin = '0; lost_clr = '0;
    endtask

    task automatic do_reset();
        INT_RST_N = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        INT_RST_N = 1'b1;
    endtask

    typedef struct {
        logic [31:0] irq, edge_m, sw, fin, clr, req, lost;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] irq, edge_m, sw, fin, clr, req, lost);
        vec_t v;
        v.irq = irq; v.edge_m = edge_m; v.sw = sw; v.fin = fin; v.clr = clr;
        v.req = req; v.lost = lost;
        return v;
    endfunction

    vec_t tbl[31];

    initial begin
        tbl[0]  = mk(32'h00, 32'h0, 32'h0, 32'h00, 32'h0, 32'h00, 32'h0);
        tbl[1]  = mk(32'h08, 32'h8, 32'h0, 32'h00, 32'h0, 32'h08, 32'h0);
        tbl[2]  = mk(32'h00, 32'h8, 32'h0, 32'h00, 32'h0, 32'h08, 32'h0);
        tbl[3]  = mk(32'h00, 32'h8, 32'h0, 32'h08, 32'h0, 32'h00, 32'h0);
        tbl[4]  = mk(32'h00, 32'h8, 32'h0, 32'h00, 32'h0, 32'h00, 32'h0);
        tbl[5]  = mk(32'h20, 32'h8, 32'h0, 32'h00, 32'h0, 32'h20, 32'h0);
        tbl[6]  = mk(32'h20, 32'h8, 32'h0, 32'h20, 32'h0, 32'h20, 32'h0);
        tbl[7]  = mk(32'h00, 32'h8, 32'h0, 32'h00, 32'h0, 32'h20, 32'h0);
        tbl[8]  = mk(32'h00, 32'h8, 32'h0, 32'h20, 32'h0, 32'h00, 32'h0);
        tbl[9]  = mk(32'h01, 32'h9, 32'h0, 32'h00, 32'h0, 32'h01, 32'h0);
        tbl[10] = mk(32'h00, 32'h9, 32'h0, 32'h00, 32'h0, 32'h01, 32'h0);
        tbl[11] = mk(32'h01, 32'h9, 32'h0, 32'h00, 32'h0, 32'h01, 32'h1);
        tbl[12] = mk(32'h00, 32'h9, 32'h0, 32'h00, 32'h1, 32'h01, 32'h0);
        tbl[13] = mk(32'h01, 32'h9, 32'h0, 32'h01, 32'h0, 32'h01, 32'h0);
        tbl[14] = mk(32'h00, 32'h9, 32'h0, 32'h01, 32'h0, 32'h00, 32'h0);
        tbl[15] = mk(32'h01, 32'h9, 32'h0, 32'h00, 32'h0, 32'h01, 32'h0);
        tbl[16] = mk(32'h00, 32'h9, 32'h0, 32'h00, 32'h0, 32'h01, 32'h0);
        tbl[17] = mk(32'h01, 32'h9, 32'h0, 32'h00, 32'h1, 32'h01, 32'h1);
        tbl[18] = mk(32'h00, 32'h9, 32'h0, 32'h01, 32'h1, 32'h00, 32'h0);
        tbl[19] = mk(32'h00, 32'h0, 32'h2, 32'h02, 32'h0, 32'h02, 32'h0);
        tbl[20] = mk(32'h00, 32'h0, 32'h0, 32'h00, 32'h0, 32'h02, 32'h0);
        tbl[21] = mk(32'h00, 32'h0, 32'h0, 32'h02, 32'h0, 32'h00, 32'h0);
        tbl[22] = mk(32'h20, 32'h0, 32'h0, 32'h00, 32'h0, 32'h20, 32'h0);
        tbl[23] = mk(32'h20, 32'h0, 32'h0, 32'h00, 32'h0, 32'h20, 32'h0);
        tbl[24] = mk(32'h20, 32'h20, 32'h0, 32'h20, 32'h0, 32'h00, 32'h0);
        tbl[25] = mk(32'h20, 32'h20, 32'h0, 32'h00, 32'h0, 32'h00, 32'h0);
        tbl[26] = mk(32'h20, 32'h0, 32'h0, 32'h00, 32'h0, 32'h20, 32'h0);
        tbl[27] = mk(32'h00, 32'h0, 32'h0, 32'h20, 32'h0, 32'h00, 32'h0);
        tbl[28] = mk(32'h01, 32'h1, 32'h0, 32'h00, 32'h0, 32'h01, 32'h0);
        tbl[29] = mk(32'h00, 32'h1, 32'h1, 32'h00, 32'h0, 32'h01, 32'h0);
        tbl[30] = mk(32'h00, 32'h1, 32'h0, 32'h01, 32'h0, 32'h00, 32'h0);

        clear_inputs();
        INT_RST_N = 1'b0;
        model_reset();

        // Reset held with every line high.
        irq_in = 32'hFFFF_FFFF;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_hold.int_req", int_req, 32'h0);
        chk("rst_hold.irq_lost", irq_lost, 32'h0);
        chk("rst_hold.irq_any", {31'd0, irq_any}, 32'h0);
        irq_in = '0;
        INT_RST_N = 1'b1;
        tick();
        chk("rst_release.int_req", int_req, 32'h0);

`ifndef IRQ_SYNC_EN
        foreach (tbl[r]) begin
            irq_in = tbl[r].irq; irq_edge = tbl[r].edge_m; sw_set = tbl[r].sw;
            int_fin = tbl[r].fin; lost_clr = tbl[r].clr;
            tick();
            chk($sformatf("vec%0d.int_req", r), int_req, tbl[r].req);
            chk($sformatf("vec%0d.irq_lost", r), irq_lost, tbl[r].lost);
            chk($sformatf("vec%0d.irq_any", r), {31'd0, irq_any}, {31'd0, |tbl[r].req});
        end
        clear_inputs();

        // Line already high when reset releases is a rising edge.
        irq_in = 32'h10; irq_edge = 32'h10;
        do_reset();
        tick();
        chk("high_at_release.int_req", int_req, 32'h10);
`else
        // Synchronizer adds two cycles to the capture latency.
        irq_edge = 32'h80; irq_in = 32'h80;
        tick();
        chk("sync_lat1.int_req", int_req, 32'h0);
        irq_in = '0;
        tick();
        chk("sync_lat2.int_req", int_req, 32'h0);
        tick();
        chk("sync_lat3.int_req", int_req, 32'h80);
        int_fin = 32'h80;
        tick();
        int_fin = '0;
        chk("sync_fin.int_req", int_req, 32'h0);
        // Reset while the pulse is still inside the chain.
        irq_in = 32'h80;
        tick();
        irq_in = '0;
        #2 INT_RST_N = 1'b0;
        model_reset();
        #1;
        chk("sync_midrst.int_req", int_req, 32'h0);
        @(posedge clock);
        #1 INT_RST_N = 1'b1;
        repeat (4) tick();
        chk("sync_no_late.int_req", int_req, 32'h0);
`endif
        clear_inputs();
        do_reset();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            if (c % 37 == 0) irq_edge = $urandom;
            irq_in   = $urandom;
            sw_set   = $urandom & $urandom & $urandom;
            int_fin  = $urandom & $urandom;
            lost_clr = $urandom & $urandom & $urandom;
            tick();
            check_model($sformatf("rand%0d", c));
        end

        // Asynchronous reset mid-cycle must clear state without a clock edge.
        clear_inputs();
        sw_set = 32'hFFFF_FFFF;
        tick();
        chk("pre_async.int_req", int_req, 32'hFFFF_FFFF);
        sw_set = '0;
        #2 INT_RST_N = 1'b0;
        model_reset();
        #1;
        chk("async_rst.int_req", int_req, 32'h0);
        chk("async_rst.irq_any", {31'd0, irq_any}, 32'h0);
        @(posedge clock);
        #1 INT_RST_N = 1'b1;
        repeat (3) tick();
        check_model("post_async");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
